block_mem_ctrl: RTL and testbench
=================================

Name: block_mem_ctrl

Overview:
- Main-memory controller directly downstream of the direct-mapped write-back cache.
- Services one 128-bit block read (allocate) or block write (write-back) at a time, over a req/ack handshake with fixed, parameterised latency.
- Owns a synchronous block-storage array and per-type access counters.
- Replaces the zero-latency combinational memory model used by cache benches.

Parameters:
- ADDR_WIDTH, 28, block address width (cpu address bits [31:4]).
- DATA_WIDTH, 128, block width in bits (4 words).
- DEPTH_LOG2, 10, log2 of the number of stored blocks.
- LATENCY, 4, wait cycles from acceptance to array access; legal range is 1 or more.
- CNT_WIDTH, 16, width of the access counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- mem_req  in  1  request valid (level).
- mem_we  in  1  1 = block write (write-back), 0 = block read (allocate).
- mem_addr  in  ADDR_WIDTH  block address.
- mem_wdata  in  DATA_WIDTH  write block.
- mem_ready  out  1  controller idle; a request can be accepted.
- mem_ack  out  1  one-cycle completion pulse.
- mem_rdata  out  DATA_WIDTH  read block; valid while mem_ack=1.
- mem_err  out  1  out-of-range access; valid while mem_ack=1.
- rd_count  out  CNT_WIDTH  completed in-range reads, wraps.
- wr_count  out  CNT_WIDTH  completed in-range writes, wraps.

Behaviour:
- Reset values: state IDLE, mem_ready=1, mem_ack=0, mem_rdata=0, mem_err=0, rd_count=0, wr_count=0, internal counter=0.
- Reset does not clear the storage array. The array is zero-initialised at simulation start only.
- States are IDLE, WAIT and RESP.
- IDLE:
  - mem_ready=1.
  - At a clock edge with mem_req=1, latch mem_we, mem_addr and mem_wdata, load cnt=LATENCY-1, and go to WAIT. This edge is the acceptance edge A.
- WAIT:
  - mem_ready=0.
  - At each edge with cnt!=0, decrement cnt.
  - At the edge with cnt==0, perform the array access using the latched values and go to RESP.
- RESP:
  - mem_ack=1 for exactly one cycle, then return to IDLE unconditionally.
- Latency: mem_ack is high in the cycle that starts at edge A+LATENCY. With LATENCY=4, a request accepted at edge 0 gets its ack in the cycle after edge 4.
- Array access at the end of WAIT:
  - A location is in range when the latched address bits [ADDR_WIDTH-1:DEPTH_LOG2] are all zero. The location index is addr[DEPTH_LOG2-1:0].
  - Write, in range: store wdata and increment wr_count.
  - Read, in range: register the array word into mem_rdata and increment rd_count.
  - Out of range: no array write, mem_rdata=0, mem_err=1, no counter increment.
  - Out-of-range writes are errored, not aliased.
- mem_rdata and mem_err:
  - Held stable after RESP until the next access completes.
  - mem_err clears on the next completion that is in range.
- Handshake:
  - Only one request is outstanding at a time.
  - mem_req is ignored in WAIT and RESP.
  - The requester holds mem_req, mem_we, mem_addr and mem_wdata stable until acceptance. Inputs are don't-care after the acceptance edge.
  - The requester drops mem_req in the ack cycle. If mem_req is still high at the first edge in IDLE, it is treated as a new request.
- Back-to-back requests: the minimum spacing between acceptance edges is LATENCY+2 cycles.
- Read after write to the same address returns the newly written data.
- Counter wrap: all-ones + 1 = 0, with no saturation and no flag.
- Reset mid-operation: an in-flight request is dropped. A pending write is not performed, no ack is issued, and the block returns to IDLE at the next edge.
- reset has priority over every other event at the same edge.

Decomposition:
- Package memCtrlPackage holds:
  - typedef enum memctrl_state_t {MC_IDLE, MC_WAIT, MC_RESP};
  - localparam BLOCK_BITS=128;
  - localparam BLOCK_ADDR_LSB=4.
- Sub-module block_ram holds the storage:
  - Synchronous single-port array, 2**DEPTH_LOG2 x DATA_WIDTH.
  - Ports: clk, en, we, addr, wdata, rdata.
  - Registered read.
  - Instantiated once.
- block_mem_ctrl contains the FSM, latency counter, range check and access counters.

Test Plan:
- Latency: LATENCY=4; write 0x0000_0001 with data 0x11112222_33334444_55556666_77778888, req accepted at edge 0 -> mem_ack high only in the cycle after edge 4, mem_ready low for edges 1-4, wr_count=1.
- Read after write: read 0x0000_0001 -> ack after 4 cycles, mem_rdata=0x11112222_33334444_55556666_77778888, mem_err=0, rd_count=1.
- Out of range: DEPTH_LOG2=10; write 0x0000_0400 with data all-ones, then read 0x0000_0000 -> first ack has mem_err=1 and wr_count unchanged; location 0 still reads its previous value.
- Held request: mem_req held high through ack -> a second identical request is accepted at the first IDLE edge, and acceptance edges are LATENCY+2=6 edges apart.
- Reset mid-op: write 0x0000_0002 with data 0xAA..AA, assert reset for 1 cycle while in WAIT at cnt=2 -> no ack, state IDLE, counters 0; a later read of 0x0000_0002 returns its prior contents.
- Counter wrap: CNT_WIDTH=2; five in-range reads -> rd_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/block_mem_ctrl_pkg.sv
// Shared types and constants for the block memory controller.
// Exports memctrl_state_t, BLOCK_BITS and BLOCK_ADDR_LSB.
package memCtrlPackage;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_WAIT,
    MC_RESP
  } memctrl_state_t;

  localparam int BLOCK_BITS     = 128;
  localparam int BLOCK_ADDR_LSB = 4;

endpackage

// File: rtl/block_mem_ctrl_if.sv
// Block request/ack bus between the write-back cache and memory.
// master: cache side (drives req/we/addr/wdata); slave: controller.
interface block_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
);

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_err;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_ack,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_ack,
    output mem_rdata,
    output mem_err
  );

endinterface

// File: rtl/block_mem_ctrl_ram.sv
// Single-port synchronous block store with registered read.
// Ports: clk, en, we, addr, wdata, rdata (updates only on enabled reads).
module block_ram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/block_mem_ctrl.sv
// Fixed-latency block memory controller: IDLE -> WAIT -> RESP FSM.
// Ports: clk, reset (sync, high), bus (slave), rd_count, wr_count.
module block_mem_ctrl
  import memCtrlPackage::*;
#(
  parameter int ADDR_WIDTH = 32 - BLOCK_ADDR_LSB,
  parameter int DATA_WIDTH = BLOCK_BITS,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  block_mem_ctrl_if.slave      bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  memctrl_state_t        state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  rd_src_q, rd_src_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_d, wr_cnt_d;
  logic                  access;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign in_range = (addr_q[ADDR_WIDTH-1:DEPTH_LOG2] == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MC_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rd_src_q <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rd_src_q <= rd_src_d;
      rd_count <= rd_cnt_d;
      wr_count <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rd_src_d = rd_src_q;
    rd_cnt_d = rd_count;
    wr_cnt_d = wr_count;
    access   = 1'b0;
    unique case (state_q)
      MC_IDLE: begin
        if (bus.mem_req) begin
          we_d    = bus.mem_we;
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          cnt_d   = CNT_INIT;
          state_d = MC_WAIT;
        end
      end
      MC_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          state_d = MC_RESP;
          err_d   = !in_range;
          // rd_src selects the RAM read register or zero; a
          // write leaves the previous read result in place.
          if (!in_range) begin
            rd_src_d = 1'b0;
          end else if (we_q) begin
            wr_cnt_d = wr_count + 1'b1;
          end else begin
            rd_src_d = 1'b1;
            rd_cnt_d = rd_count + 1'b1;
          end
        end
      end
      MC_RESP: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  block_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (access && in_range),
    .we    (we_q),
    .addr  (addr_q[DEPTH_LOG2-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.mem_ready = (state_q == MC_IDLE);
  assign bus.mem_ack   = (state_q == MC_RESP);
  assign bus.mem_rdata = rd_src_q ? ram_rdata : '0;
  assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Directed bench for block_mem_ctrl: vector table plus
// hand sequences for reset-in-flight, held request and wrap.
module tb_block_mem_ctrl;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int CNTW = 2;

  localparam logic [DW-1:0] D1 =
    128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DW-1:0] D0 =
    128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [DW-1:0] D2 =
    128'hcafe_0000_beef_1111_dead_2222_f00d_3333;
  localparam logic [DW-1:0] D3 =
    128'h5a5a_5a5a_0000_ffff_a5a5_a5a5_1234_5678;
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] AAS =
    128'haaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CNTW-1:0] rd_count, wr_count;

  int checks = 0;
  int failures = 0;

  block_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  block_mem_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH_LOG2 (10),
    .LATENCY    (4),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          chk_rd;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_rd;
    int            exp_wr;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE and drop it after acceptance.
  // lat = edges from acceptance until ack is seen (-1 on timeout).
  task automatic run_req(input logic we,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d,
                         output int lat,
                         output logic rdy_low);
    @(negedge clk);
    chk("ready_before_req", DW'(bus.mem_ready), DW'(1));
    bus.mem_we    = we;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_req   = 1'b0;
    bus.mem_we    = ~we;
    bus.mem_addr  = ~a;
    bus.mem_wdata = ~d;
    rdy_low = !bus.mem_ready;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_ready) rdy_low = 1'b0;
      if (bus.mem_ack) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_idle_after_ack();
    @(posedge clk);
    @(negedge clk);
    chk("ack_one_cycle", DW'(bus.mem_ack), DW'(0));
    chk("ready_after_resp", DW'(bus.mem_ready), DW'(1));
  endtask

  initial begin
    int lat;
    logic rl;
    int k;
    logic seen;

    vecs[0] = '{1'b1, 28'h0000001, D1,   1'b0, '0, 1'b0, 0, 1};
    vecs[1] = '{1'b0, 28'h0000001, '0,   1'b1, D1, 1'b0, 1, 1};
    vecs[2] = '{1'b1, 28'h0000000, D0,   1'b0, '0, 1'b0, 1, 2};
    vecs[3] = '{1'b1, 28'h0000400, ONES, 1'b1, '0, 1'b1, 1, 2};
    vecs[4] = '{1'b0, 28'h0000000, '0,   1'b1, D0, 1'b0, 2, 2};
    vecs[5] = '{1'b1, 28'h0000002, D2,   1'b0, '0, 1'b0, 2, 3};
    vecs[6] = '{1'b0, 28'h0000002, '0,   1'b1, D2, 1'b0, 3, 3};
    vecs[7] = '{1'b0, 28'h8000001, '0,   1'b1, '0, 1'b1, 3, 3};
    vecs[8] = '{1'b0, 28'h0000001, '0,   1'b1, D1, 1'b0, 0, 3};
    vecs[9] = '{1'b1, 28'h0000003, D3,   1'b0, '0, 1'b0, 0, 0};

    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_ready", DW'(bus.mem_ready), DW'(1));
    chk("rst_ack", DW'(bus.mem_ack), DW'(0));
    chk("rst_rdata", bus.mem_rdata, '0);
    chk("rst_err", DW'(bus.mem_err), DW'(0));
    chk("rst_rd_count", DW'(rd_count), DW'(0));
    chk("rst_wr_count", DW'(wr_count), DW'(0));

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rl);
      chk($sformatf("v%0d_latency", i), DW'(lat), DW'(4));
      chk($sformatf("v%0d_ready_low", i), DW'(rl), DW'(1));
      chk($sformatf("v%0d_err", i), DW'(bus.mem_err),
          DW'(vecs[i].exp_err));
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d_rdata", i), bus.mem_rdata,
            vecs[i].exp_rdata);
      chk($sformatf("v%0d_rd_count", i), DW'(rd_count),
          DW'(vecs[i].exp_rd));
      chk($sformatf("v%0d_wr_count", i), DW'(wr_count),
          DW'(vecs[i].exp_wr));
      check_idle_after_ack();
      chk($sformatf("v%0d_err_held", i), DW'(bus.mem_err),
          DW'(vecs[i].exp_err));
    end

    // Reset while in WAIT with cnt=2: the write to 2 must vanish.
    @(negedge clk);
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 28'h0000002;
    bus.mem_wdata = AAS;
    bus.mem_req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_ready", DW'(bus.mem_ready), DW'(1));
    chk("rstmid_rd_count", DW'(rd_count), DW'(0));
    chk("rstmid_wr_count", DW'(wr_count), DW'(0));
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_ack) seen = 1'b1;
    end
    chk("rstmid_no_ack", DW'(seen), DW'(0));
    chk("rstmid_wr_still0", DW'(wr_count), DW'(0));

    run_req(1'b0, 28'h0000002, '0, lat, rl);
    chk("rstmid_read_lat", DW'(lat), DW'(4));
    chk("rstmid_read_data", bus.mem_rdata, D2);
    chk("rstmid_read_cnt", DW'(rd_count), DW'(1));
    check_idle_after_ack();

    // Counter wrap: rd_count continues 2,3,0,1.
    for (int j = 0; j < 4; j++) begin
      run_req(1'b0, 28'h0000003, '0, lat, rl);
      chk($sformatf("wrap%0d_data", j), bus.mem_rdata, D3);
      chk($sformatf("wrap%0d_rd_count", j), DW'(rd_count),
          DW'((j + 2) % 4));
      check_idle_after_ack();
    end

    // Held request: second acceptance 6 edges after the first.
    @(negedge clk);
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 28'h0000001;
    bus.mem_wdata = '0;
    bus.mem_req   = 1'b1;
    @(posedge clk);
    k = 0;
    seen = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.mem_ack) seen = 1'b1;
      if (bus.mem_ready) break;
      @(posedge clk);
      k++;
    end
    chk("held_first_ack", DW'(seen), DW'(1));
    chk("held_spacing", DW'(k + 1), DW'(6));
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    chk("held_accepted", DW'(bus.mem_ready), DW'(0));
    lat = -1;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_ack) begin
        lat = j;
        break;
      end
    end
    chk("held_second_lat", DW'(lat), DW'(4));
    chk("held_second_data", bus.mem_rdata, D1);
    chk("held_rd_count", DW'(rd_count), DW'(3));
    check_idle_after_ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
